forwarding_hazard_unit: RTL and testbench

- Sequential forwarding and load-use hazard controller for the 5-stage MIPS pipeline.
- Keeps a shadow pipeline of destination-register metadata for the EX, MEM and WB stages.
- Produces the 2-bit select codes for the two 32-bit 3:1 ALU-operand muxes in EX, plus a load-use stall request to IF/ID.
- Sits directly upstream of the operand muxes and drives their sel inputs.

---
 rtl/forwarding_hazard_unit.sv | 138 +++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit
//
// Forwarding and load-use hazard controller for a 5-stage MIPS pipeline.
// It keeps a shadow copy of the register metadata for the instructions in EX,
// MEM and WB. From that copy it drives the select codes of the two ALU-operand
// muxes in EX, and it raises a load-use stall request back to IF/ID.
//
// Operand mux select encoding:
//   00 ID/EX register-file value
//   01 MEM/WB writeback data
//   10 EX/MEM ALU result
//   11 never driven
//
// Ports:
//   Clk         pipeline clock, rising edge
//   Rst         asynchronous active-high reset
//   Freeze      global pipeline hold; all internal state holds
//   Flush       squash the ID-stage instruction
//   IdRs/IdRt   source register fields of the ID instruction
//   IdUseRs/Rt  ID instruction actually reads rs / rt
//   IdDst       destination register of the ID instruction (already muxed)
//   IdRegWrite  ID instruction writes the register file
//   IdMemRead   ID instruction is a load
//   FwdA/FwdB   select codes for the ALU operand A / B muxes
//   Stall       hold PC and IF/ID, insert a bubble into EX
//   StallCount  saturating count of stall cycles taken
// ---------------------------------------------------------------------------
module forwarding_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Freeze,
  input  logic              Flush,
  input  logic [REG_AW-1:0] IdRs,
  input  logic [REG_AW-1:0] IdRt,
  input  logic              IdUseRs,
  input  logic              IdUseRt,
  input  logic [REG_AW-1:0] IdDst,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic              Stall,
  output logic [CNT_W-1:0]  StallCount
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] mem_dst;
  logic              mem_reg_write;
  logic [REG_AW-1:0] wb_dst;
  logic              wb_reg_write;
  logic [CNT_W-1:0]  stall_count;

  logic hazard;
  logic bubble;

  // A load in EX whose result the ID instruction needs cannot be forwarded
  // in time, so the ID instruction has to wait one cycle.
  always_comb begin
    hazard = ex_mem_read && (ex_dst != '0) &&
             ((IdUseRs && (IdRs == ex_dst)) || (IdUseRt && (IdRt == ex_dst)));
  end

  // A squashed instruction is discarded anyway, so it never needs to wait.
  assign Stall  = hazard && !Flush;
  assign bubble = Flush || Stall;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dst        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_dst       <= '0;
      mem_reg_write <= 1'b0;
      wb_dst        <= '0;
      wb_reg_write  <= 1'b0;
      stall_count   <= '0;
    end else if (!Freeze) begin
      mem_dst       <= ex_dst;
      mem_reg_write <= ex_reg_write;
      wb_dst        <= mem_dst;
      wb_reg_write  <= mem_reg_write;
      if (bubble) begin
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_dst       <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_rs        <= IdRs;
        ex_rt        <= IdRt;
        ex_dst       <= IdDst;
        ex_reg_write <= IdRegWrite;
        ex_mem_read  <= IdMemRead;
      end
      // Saturate rather than wrap so that a long run never reads back as small.
      if (Stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  // MEM is checked first because it holds the newer value of the register.
  // These selects depend only on registered state.
  always_comb begin
    FwdA = SEL_RF;
    if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rs)) begin
      FwdA = SEL_MEM;
    end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rs)) begin
      FwdA = SEL_WB;
    end
  end

  always_comb begin
    FwdB = SEL_RF;
    if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rt)) begin
      FwdB = SEL_MEM;
    end else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rt)) begin
      FwdB = SEL_WB;
    end
  end

  assign StallCount = stall_count;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// Bench for forwarding_hazard_unit. A small pipeline model (an array of
// instruction records, newest first) predicts the outputs on every cycle.
// Directed instruction sequences drive the design, and hand-computed literal
// expectations pin the behaviour at the key points. The stall counter is
// narrowed so that saturation can be reached quickly.
// ---------------------------------------------------------------------------
module tb_forwarding_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              Clk;
  logic              Rst;
  logic              Freeze;
  logic              Flush;
  logic [REG_AW-1:0] IdRs;
  logic [REG_AW-1:0] IdRt;
  logic              IdUseRs;
  logic              IdUseRt;
  logic [REG_AW-1:0] IdDst;
  logic              IdRegWrite;
  logic              IdMemRead;
  logic [1:0]        FwdA;
  logic [1:0]        FwdB;
  logic              Stall;
  logic [CNT_W-1:0]  StallCount;

  int checks   = 0;
  int failures = 0;
  bit compare_en = 0;

  forwarding_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Freeze(Freeze), .Flush(Flush),
    .IdRs(IdRs), .IdRt(IdRt), .IdUseRs(IdUseRs), .IdUseRt(IdUseRt),
    .IdDst(IdDst), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .FwdA(FwdA), .FwdB(FwdB), .Stall(Stall), .StallCount(StallCount)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  // ---------------- model ----------------
  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              ld;
  } rec_t;

  rec_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int   m_count;

  // The youngest older writer of a register supplies it: age 1 is MEM (10),
  // age 2 is WB (01). Register 0 is never supplied.
  function automatic logic [1:0] m_fwd(logic [REG_AW-1:0] r);
    if (r == 0) return 2'b00;
    for (int age = 1; age <= 2; age++) begin
      if (pipe[age].wr && pipe[age].dst == r) return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    logic needs;
    needs = (IdUseRs && IdRs == pipe[0].dst) || (IdUseRt && IdRt == pipe[0].dst);
    return pipe[0].ld && pipe[0].dst != 0 && needs && !Flush;
  endfunction

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '0;
      m_count <= 0;
    end else if (!Freeze) begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      if (Flush || m_stall()) pipe[0] <= '0;
      else pipe[0] <= '{rs: IdRs, rt: IdRt, dst: IdDst, wr: IdRegWrite, ld: IdMemRead};
      if (m_stall() && m_count < CNT_MAX) m_count <= m_count + 1;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (compare_en) begin
      cmp("model_fwda", int'(FwdA), int'(m_fwd(pipe[0].rs)));
      cmp("model_fwdb", int'(FwdB), int'(m_fwd(pipe[0].rt)));
      cmp("model_stall", int'(Stall), int'(m_stall()));
      cmp("model_count", int'(StallCount), m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_id(input int rs, input int rt, input bit urs, input bit urt,
                        input int dst, input bit wr, input bit ld);
    IdRs       = REG_AW'(rs);
    IdRt       = REG_AW'(rt);
    IdUseRs    = urs;
    IdUseRt    = urt;
    IdDst      = REG_AW'(dst);
    IdRegWrite = wr;
    IdMemRead  = ld;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int cnt_before;

  initial begin
    Rst = 1; Freeze = 0; Flush = 0;
    set_id(0, 0, 0, 0, 5, 1, 1);
    #2 compare_en = 1;
    #10;
    cmp("rst_fwda", int'(FwdA), 0);
    cmp("rst_fwdb", int'(FwdB), 0);
    cmp("rst_stall", int'(Stall), 0);
    cmp("rst_count", int'(StallCount), 0);

    // Release reset away from the edge; the first edge loads the load of $5.
    @(negedge Clk); Rst = 0;
    tick();
    set_id(5, 0, 1, 0, 6, 1, 0);
    #1 cmp("first_edge_loads_ex", int'(Stall), 1);
    Flush = 1;
    #1 cmp("flush_masks_stall", int'(Stall), 0);
    tick();
    Flush = 0; nop();
    #1 cmp("flush_count_unchanged", int'(StallCount), 0);

    // add $3,$1,$2 ; sub $4,$3,$3
    set_id(1, 2, 1, 1, 3, 1, 0); tick();
    set_id(3, 3, 1, 1, 4, 1, 0); tick();
    nop();
    cmp("exmem_fwda", int'(FwdA), 2);
    cmp("exmem_fwdb", int'(FwdB), 2);

    // write $7, nop, reader of $7
    set_id(0, 0, 0, 0, 7, 1, 0); tick();
    nop(); tick();
    set_id(7, 0, 1, 1, 8, 1, 0); tick();
    nop();
    cmp("memwb_fwda", int'(FwdA), 1);
    cmp("memwb_fwdb", int'(FwdB), 0);

    // write $7 twice, then reader: newest (MEM) wins
    set_id(0, 0, 0, 0, 7, 1, 0); tick();
    set_id(0, 0, 0, 0, 7, 1, 0); tick();
    set_id(0, 7, 1, 1, 8, 1, 0); tick();
    nop();
    cmp("priority_fwdb", int'(FwdB), 2);
    tick(); tick();

    // lw $8 ; add $9,$8,$0
    set_id(0, 0, 0, 0, 8, 1, 1); tick();
    set_id(8, 0, 1, 1, 9, 1, 0);
    #1 cmp("loaduse_stall", int'(Stall), 1);
    tick();
    cmp("loaduse_one_cycle", int'(Stall), 0);
    cmp("loaduse_count", int'(StallCount), 1);
    cmp("bubble_in_ex_fwda", int'(FwdA), 0);
    tick();
    nop();
    cmp("loaduse_fwda", int'(FwdA), 1);
    tick(); tick();

    // $zero: a load writing $0 and a reader of $0
    set_id(0, 0, 0, 0, 0, 1, 1); tick();
    set_id(0, 0, 1, 1, 9, 1, 0);
    #1 cmp("zero_no_stall", int'(Stall), 0);
    tick();
    nop();
    cmp("zero_fwda", int'(FwdA), 0);
    tick(); tick();

    // Freeze during forwarding: w $10, reader, freeze 3, reader resumes
    set_id(0, 0, 0, 0, 10, 1, 0); tick();
    set_id(10, 0, 1, 0, 11, 1, 0); tick();
    set_id(10, 0, 1, 0, 12, 1, 0);
    cmp("pre_freeze_fwda", int'(FwdA), 2);
    Freeze = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("frozen_fwda", int'(FwdA), 2);
    end
    Freeze = 0;
    tick();
    nop();
    cmp("resume_fwda", int'(FwdA), 1);
    tick(); tick();

    // Freeze while a load-use hazard is pending: Stall shows, count holds
    set_id(0, 0, 0, 0, 11, 1, 1); tick();
    set_id(11, 0, 1, 0, 12, 1, 0);
    cnt_before = int'(StallCount);
    Freeze = 1;
    tick(); tick();
    cmp("frozen_stall_visible", int'(Stall), 1);
    cmp("frozen_count_holds", int'(StallCount), cnt_before);
    Freeze = 0;
    tick();
    cmp("count_after_release", int'(StallCount), cnt_before + 1);
    nop(); tick(); tick();

    // Long stall run to saturate the counter: a load of $12 that reads $12
    set_id(0, 0, 0, 0, 12, 1, 1); tick();
    set_id(12, 0, 1, 0, 12, 1, 1);
    for (int i = 0; i < 40; i++) tick();
    cmp("count_saturated", int'(StallCount), CNT_MAX);
    tick(); tick();
    cmp("count_stays_saturated", int'(StallCount), CNT_MAX);
    nop(); tick(); tick();

    // Mid-operation reset discards in-flight metadata
    set_id(0, 0, 0, 0, 13, 1, 0); tick();
    set_id(13, 13, 1, 1, 14, 1, 0); tick();
    cmp("pre_reset_fwda", int'(FwdA), 2);
    #2 Rst = 1;
    #1;
    cmp("midrst_fwda", int'(FwdA), 0);
    cmp("midrst_count", int'(StallCount), 0);
    @(negedge Clk); Rst = 0;
    tick();

    compare_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
